// File: rtl/debruijn_checker.sv
// rtl/debruijn_checker.sv - serial lock/position/error checker for the 4-bit de Bruijn stream
//
// Optional feature macro: DEBRUIJN_ERRCNT_EN (saturating 8-bit error counter).
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   en       in   one-cycle sample strobe per received bit
//   din      in   received serial bit (generator state[0])
//   locked   out  1 while tracking the stream
//   pos      out  sequence index 0..15 of the current window
//   window   out  last four received bits, newest in [3]
//   err      out  one-cycle pulse on a mispredicted bit while locked
//   err_cnt  out  saturating error count (0 when the counter is not built)

module debruijn_checker #(
    parameter int LOSS_THRESH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       din,
    output logic       locked,
    output logic [3:0] pos,
    output logic [3:0] window,
    output logic       err,
    output logic [7:0] err_cnt
);

    typedef enum logic {ACQ, TRACK} state_t;

    localparam logic [2:0] LOSS_LIM = 3'(LOSS_THRESH);

    state_t     state;
    logic [2:0] fill_cnt;
    logic [2:0] miss_cnt;
    logic [3:0] next_window;
    logic       predicted;
    logic       mismatch;

    assign next_window = {din, window[3:1]};
    // Generator recurrence applied to the window gives the bit it emits next.
    assign predicted   = window[1] ^ window[0] ^ ~(window[3] | window[2] | window[1]);
    assign mismatch    = (state == TRACK) && (din != predicted);

    // Position of a window in the canonical generator order.
    function automatic logic [3:0] window_index(input logic [3:0] w);
        logic [3:0] idx;
        case (w)
            4'b0000: idx = 4'd0;
            4'b1000: idx = 4'd1;
            4'b0100: idx = 4'd2;
            4'b0010: idx = 4'd3;
            4'b1001: idx = 4'd4;
            4'b1100: idx = 4'd5;
            4'b0110: idx = 4'd6;
            4'b1011: idx = 4'd7;
            4'b0101: idx = 4'd8;
            4'b1010: idx = 4'd9;
            4'b1101: idx = 4'd10;
            4'b1110: idx = 4'd11;
            4'b1111: idx = 4'd12;
            4'b0111: idx = 4'd13;
            4'b0011: idx = 4'd14;
            default: idx = 4'd15;
        endcase
        return idx;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACQ;
            locked   <= 1'b0;
            pos      <= 4'd0;
            window   <= 4'd0;
            err      <= 1'b0;
            fill_cnt <= 3'd0;
            miss_cnt <= 3'd0;
        end else begin
            err <= 1'b0;
            if (en) begin
                // The actual bit always enters the window, even when it was wrong,
                // so a corrupted bit shows up as a jump in pos.
                window <= next_window;
                pos    <= window_index(next_window);
                case (state)
                    ACQ: begin
                        if (fill_cnt == 3'd3) begin
                            state    <= TRACK;
                            locked   <= 1'b1;
                            fill_cnt <= 3'd0;
                            miss_cnt <= 3'd0;
                        end else begin
                            fill_cnt <= fill_cnt + 3'd1;
                        end
                    end
                    TRACK: begin
                        if (mismatch) begin
                            err <= 1'b1;
                            if (miss_cnt + 3'd1 == LOSS_LIM) begin
                                state    <= ACQ;
                                locked   <= 1'b0;
                                fill_cnt <= 3'd0;
                                miss_cnt <= 3'd0;
                            end else begin
                                miss_cnt <= miss_cnt + 3'd1;
                            end
                        end else begin
                            miss_cnt <= 3'd0;
                        end
                    end
                    default: state <= ACQ;
                endcase
            end
        end
    end

`ifdef DEBRUIJN_ERRCNT_EN
    // Survives loss of lock; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else if (en && mismatch && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_debruijn_checker.sv
// tb/tb_debruijn_checker.sv - self-checking bench for debruijn_checker

module tb_debruijn_checker;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       din = 1'b0;
    logic       locked;
    logic [3:0] pos;
    logic [3:0] window;
    logic       err;
    logic [7:0] err_cnt;

    logic       s_rst = 1'b1;
    logic       s_en  = 1'b0;
    logic       s_din = 1'b0;
    logic       s_locked;
    logic [3:0] s_pos;
    logic [3:0] s_window;
    logic       s_err;
    logic [7:0] s_err_cnt;

    debruijn_checker #(.LOSS_THRESH(2)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din),
        .locked(locked), .pos(pos), .window(window), .err(err), .err_cnt(err_cnt)
    );

    debruijn_checker #(.LOSS_THRESH(7)) u_sat (
        .clk(clk), .rst(s_rst), .en(s_en), .din(s_din),
        .locked(s_locked), .pos(s_pos), .window(s_window), .err(s_err), .err_cnt(s_err_cnt)
    );

`ifdef DEBRUIJN_ERRCNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct {
        logic r;
        logic e;
        logic d;
        logic xl;
        int   xp;
        logic xe;
        int   xw;
    } vec_t;

    vec_t  sb[$];
    vec_t  tbl[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    string phase    = "init";

    function automatic vec_t mk(input logic r, input logic e, input logic d,
                                input logic xl, input int xp, input logic xe, input int xw);
        vec_t v;
        v.r = r; v.e = e; v.d = d; v.xl = xl; v.xp = xp; v.xe = xe; v.xw = xw;
        return v;
    endfunction

    function automatic logic sbit(input int k);
        logic [15:0] s;
        s = 16'b0000100110101111;
        return s[15 - (k % 16)];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0d, expected %0d", phase, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t x;
        sb.push_back(v);
        rst = v.r;
        en  = v.e;
        din = v.d;
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk("locked", int'(locked), int'(x.xl));
        chk("err", int'(err), int'(x.xe));
        if (x.xp >= 0) chk("pos", int'(pos), x.xp);
        if (x.xw >= 0) chk("window", int'(window), x.xw);
    endtask

    task automatic feed_ok(input int k);
        apply(mk(0, 1, sbit(k), k >= 3, (k >= 3) ? (k - 3) % 16 : -1, 0, -1));
    endtask

    initial begin
        logic [3:0] w;
        logic       p;
        logic       xe;
        logic       eq[$];
        int         sat_bad;

        // Table: reset, clean lock with wrap, mid-phase acquisition.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 24; i++)
            tbl.push_back(mk(0, 1, sbit(i), i >= 3, (i >= 3) ? (i - 3) % 16 : -1, 0, -1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, -1, 0, 4'b1000));
        tbl.push_back(mk(0, 1, 0, 0, -1, 0, 4'b0100));
        tbl.push_back(mk(0, 1, 1, 0, -1, 0, 4'b1010));
        tbl.push_back(mk(0, 1, 0, 1, 8, 0, 4'b0101));
        tbl.push_back(mk(0, 1, 1, 1, 9, 0, 4'b1010));

        phase = "table";
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
        chk("err_cnt_clean", int'(err_cnt), 0);

        // Single flip while locked, with an idle cycle right after the error.
        phase = "single_flip";
        apply(mk(1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++) feed_ok(k);
        apply(mk(0, 1, 0, 1, 2, 1, 4'b0100));
        chk("err_cnt", int'(err_cnt), CNT_ON ? 1 : 0);
        apply(mk(0, 0, 1, 1, 2, 0, 4'b0100));
        apply(mk(0, 1, 0, 1, 3, 0, 4'b0010));
        chk("err_cnt_hold", int'(err_cnt), CNT_ON ? 1 : 0);

        // Two consecutive flips drop lock; four more bits reacquire.
        phase = "loss";
        apply(mk(1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++) feed_ok(k);
        apply(mk(0, 1, 0, 1, 2, 1, 4'b0100));
        apply(mk(0, 1, 1, 0, -1, 1, 4'b1010));
        chk("err_cnt", int'(err_cnt), CNT_ON ? 2 : 0);
        apply(mk(0, 1, sbit(10), 0, -1, 0, -1));
        apply(mk(0, 1, sbit(11), 0, -1, 0, -1));
        apply(mk(0, 1, sbit(12), 0, -1, 0, -1));
        apply(mk(0, 1, sbit(13), 1, 10, 0, 4'b1101));
        apply(mk(0, 1, sbit(14), 1, 11, 0, 4'b1110));
        chk("err_cnt_after_relock", int'(err_cnt), CNT_ON ? 2 : 0);

        // Gating then reset with en.
        phase = "gating";
        for (int i = 0; i < 3; i++) apply(mk(0, 0, i[0], 1, 11, 0, 4'b1110));
        chk("err_cnt_gated", int'(err_cnt), CNT_ON ? 2 : 0);
        apply(mk(1, 1, 1, 0, 0, 0, 0));
        chk("err_cnt_reset", int'(err_cnt), 0);
        rst = 1'b0;
        en  = 1'b0;

        // Saturation with alternating flips on the LOSS_THRESH=7 instance.
        phase   = "saturation";
        sat_bad = 0;
        s_rst   = 1'b1;
        @(posedge clk);
        #1;
        s_rst = 1'b0;
        s_en  = 1'b1;
        w     = 4'd0;
        for (int i = 0; i < 4; i++) begin
            s_din = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("sat_locked_initial", int'(s_locked), 1);
        for (int i = 0; i < 600; i++) begin
            p     = w[1] ^ w[0] ^ ~(w[3] | w[2] | w[1]);
            s_din = (i % 2 == 0) ? ~p : p;
            eq.push_back(i % 2 == 0);
            w = {s_din, w[3:1]};
            @(posedge clk);
            #1;
            xe = eq.pop_front();
            if (s_err !== xe || s_locked !== 1'b1) sat_bad++;
            if (i == 399) chk("sat_cnt_200", int'(s_err_cnt), CNT_ON ? 200 : 0);
        end
        s_en = 1'b0;
        chk("sat_seq_errors", sat_bad, 0);
        chk("sat_cnt_final", int'(s_err_cnt), CNT_ON ? 255 : 0);
        chk("sat_window", int'(s_window), int'(w));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/debruijn_checker.md
# debruijn_checker

Serial receiver for the 4-bit de Bruijn pattern stream produced by the team's generator. Every sample step it shifts in the received bit, acquires the 4-bit window, and predicts the next bit from the generator recurrence. It reports lock, the absolute sequence position (0–15) and bit errors. It sits at the far end of a link or loopback, clocked on `clk` and advanced by the same divided-rate strobe that steps the generator.

## Interface
Parameters:
- `LOSS_THRESH`, default 2: consecutive mispredicted bits that drop lock; legal range 1–7.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: sample strobe, one `clk` cycle wide per bit; nothing advances while low.
- `din` input 1: received serial bit, corresponding to generator `state[0]`.
- `locked` output 1: window acquired and tracking.
- `pos` output 4: sequence index of the current window; meaningful only while `locked`.
- `window` output 4: last four received bits; newest bit is in `[3]`, oldest in `[0]`.
- `err` output 1: one-cycle pulse on a mispredicted bit while locked.
- `err_cnt` output 8: saturating error count; see Configuration.

## Operation
- Window shift on each `en`: `window <= {din, window[3:1]}`. The window equals the generator state at the time its oldest bit was emitted.
- Prediction: `f(w) = w[1] ^ w[0] ^ ~(w[3] | w[2] | w[1])`. The expected next `din` is `f(window)`.
- Canonical order, index 0..15: 0000, 1000, 0100, 0010, 1001, 1100, 0110, 1011, 0101, 1010, 1101, 1110, 1111, 0111, 0011, 0001, then wrap to 0000. The serial stream from index 0 is 0000100110101111.
- `pos` is the registered lookup of the post-shift window in this order. All 16 windows are valid, so `pos` is always defined.
- FSM, two states:
  - ACQ (reset state): a 3-bit fill counter counts accepted bits. On the 4th accepted bit, go to TRACK and clear the miss counter.
  - TRACK: compare `din` against `f(window)` before the shift.
    - On a match, clear the miss counter.
    - On a mismatch, pulse `err`, increment the miss counter and `err_cnt`.
    - When the miss counter reaches `LOSS_THRESH`, go to ACQ and clear the fill counter.
  - The window always shifts in the actual `din`, including on a mismatch.
- `locked` is 1 exactly while the FSM is in TRACK.
- Mismatches are never counted in ACQ.

## Timing
- Reset values: `locked` 0, `pos` 0, `window` 0000, `err` 0, `err_cnt` 0, FSM in ACQ, fill counter 0, miss counter 0.
- `rst` has priority over `en` when both are high on the same edge.
- Lock latency: on the edge that accepts the 4th bit, `locked` and `pos` are valid after that edge.
- `pos` advances by 1 mod 16 per correctly received bit, wrapping 15 to 0.
- `err` is high for exactly one `clk` cycle after the mismatching edge. It is 0 on any cycle without `en`.
- Loss of lock: on the `LOSS_THRESH`-th consecutive mismatch edge, `locked` falls and `err` pulses on the same edge.
- Re-acquisition needs 4 further accepted bits.
- `en` low: all registers hold; only `err` returns to 0.
- `rst` mid-TRACK: every output takes its reset value after the edge.

## Configuration
- `DEBRUIJN_ERRCNT_EN` defined: `err_cnt` is an 8-bit counter that increments on each `err` and saturates at 255. It clears only on `rst` and is not cleared by loss of lock.
- `DEBRUIJN_ERRCNT_EN` undefined: no counter logic is built and `err_cnt` is tied to 0. `err` and locking behave identically in both builds.

## Test plan
- Clean lock: reset, then 0000100110101111 repeated with `en` every cycle.
  - `locked` = 1 and `pos` = 0 after the 4th bit.
  - `pos` then steps 1, 2, …, 15, 0.
  - `err` never asserts.
- Mid-phase acquisition: reset, then 1,0,1,0.
  - `window` = 0101, `pos` = 8.
  - A following 1 gives `pos` = 9 with no `err`.
- Single flip while locked: invert one bit.
  - `err` pulses once and `err_cnt` = 1.
  - `locked` stays 1 with `LOSS_THRESH` = 2.
  - `pos` equals the lookup of the corrupted window.
- Loss and recovery: invert 2 consecutive bits while locked.
  - `locked` falls on the 2nd mismatch.
  - `locked` rises again 4 accepted bits later, with the correct `pos`.
- Gating and reset: hold `en` low 3 cycles mid-TRACK and all outputs are unchanged. Then assert `rst` together with `en`: all outputs return to reset values after the next edge.
- Saturation: with the macro defined, force 300 errors (alternate flips with `LOSS_THRESH` = 7) and `err_cnt` = 255. With the macro undefined, `err_cnt` stays 0 throughout.
